alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Clocked front-end that configures and sequences the 4-bit ALU datapath. It debounces the up/down mode buttons into a saturating 3-bit operation select and drives the mode LEDs. It latches operands and the select on a start request, presents them to the combinational ALU for a fixed settle window, then registers result and flags with a one-cycle done pulse. The ALU itself is instantiated outside this block and connected through the alu_* ports.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a raw button must be sampled high before it counts as pressed (min 1).
SETTLE_CYCLES, 1, cycles operands are held on the ALU before capture (min 1).

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
btn_up  in  1  raw mode-up button, asynchronous to clk
btn_down  in  1  raw mode-down button, asynchronous to clk
start  in  1  request one operation; sampled only in IDLE
a  in  4  operand A, two's complement
b  in  4  operand B, two's complement
alu_result  in  4  from ALU
alu_carry  in  1  from ALU
alu_zero  in  1  from ALU
alu_overflow  in  1  from ALU
alu_control  out  3  op select to ALU (latched)
alu_a  out  4  operand A to ALU (latched)
alu_b  out  4  operand B to ALU (latched)
control_led  out  3  current mode select
result  out  4  registered result
carry  out  1  registered carry
zero  out  1  registered zero
overflow  out  1  registered overflow
busy  out  1  high in EXEC and DONE
done  out  1  one-cycle completion pulse
op_count  out  8  completed operations, wraps 255->0

Behaviour:
- Reset (rst==0 at clk edge): all outputs 0, FSM IDLE, debounce counters 0, sync flops 0. Reset overrides everything, including mid-EXEC; the operation in flight is discarded, with no done.
- Button inputs pass through 2-flop synchronizers (2-cycle latency) before debounce.
- Debounce, per button:
  - counter increments while the synced input is 1 and saturates at DEBOUNCE_CYCLES;
  - any 0 clears the counter;
  - stable = (counter == DEBOUNCE_CYCLES);
  - press = rising edge of stable, a 1-cycle internal pulse;
  - a held button yields exactly one press.
- Mode register (drives control_led):
  - up press: +1, saturating at 7;
  - down press: -1, saturating at 0;
  - up and down presses in the same cycle: no change;
  - presses while busy: dropped, not queued; the debouncer still tracks them, so a button held through the end of busy does not produce a late press.
- FSM:
  - IDLE: busy=0. If start==1, latch a->alu_a, b->alu_b, mode->alu_control, clear settle counter, go to EXEC. A mode press in the same cycle as start is applied to mode; the latched op uses the pre-press mode.
  - EXEC: busy=1. Settle counter increments each cycle. In the cycle where counter == SETTLE_CYCLES-1, capture alu_result/carry/zero/overflow into the result registers, increment op_count, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle, then IDLE. start is ignored in EXEC and DONE.
- Timing: with start sampled at edge N, done is high during cycle N+SETTLE_CYCLES+1. With SETTLE_CYCLES=1, done is visible 2 edges after start.
- alu_a, alu_b and alu_control hold their values from latch until the next accepted start; they are not cleared after DONE.
- result and flags hold until the next capture.
- The block does not interpret op encodings; alu_control is passed through.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 and btn_up=1 -> all outputs 0; after rst=1, state stays IDLE until start is sampled again.
- Debounce, DEBOUNCE_CYCLES=4: btn_up high for 3 cycles then low -> control_led stays 0. High for 20 cycles -> control_led=1 exactly once, 2+4+1 cycles after the rise.
- Saturation: 9 clean up presses -> control_led=7. 10 down presses -> 0. Simultaneous up+down at mode 3 -> stays 3.
- Operation, SETTLE_CYCLES=1: mode=0, a=4'h3, b=4'h5; bench ALU model returns 4'h8, overflow=1. Pulse start at edge N -> alu_a=3, alu_b=5 after N; done=1 only in cycle N+2; result=8, overflow=1; op_count=1.
- Busy rejection: second start and an up press during EXEC/DONE -> ignored; op_count increments once and control_led is unchanged.
- Reset mid-op: rst=0 during EXEC -> no done pulse, op_count=0, busy=0. op_count wrap: 256 ops -> returns to 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Front-end for the 4-bit ALU: debounced mode select, operand latching,
// settle-window sequencing and registered capture of the ALU result.
module alu_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic [2:0] alu_control,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] control_led,
  output logic [3:0] result,
  output logic       carry,
  output logic       zero,
  output logic       overflow,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0]    stable, stable_q, press;
  logic [2:0]    mode_q, mode_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [2:0]    aluCtl_q, aluCtl_d;
  logic [3:0]    aluA_q, aluA_d, aluB_q, aluB_d;
  logic [6:0]    capture_q, capture_d;
  logic [7:0]    opCount_q, opCount_d;

  // Index 0 is the up button, index 1 the down button.
  assign raw = {btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]  = cnt_q[i];
      stable[i] = (cnt_q[i] == DW'(DEBOUNCE_CYCLES));
      if (!sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (!stable[i]) begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign press = stable & ~stable_q;

  // Presses are consumed only while idle; busy-time presses are simply lost.
  always_comb begin
    mode_d = mode_q;
    if (state_q == IDLE) begin
      if (press[0] && !press[1] && mode_q != 3'd7) begin
        mode_d = mode_q + 3'd1;
      end else if (press[1] && !press[0] && mode_q != 3'd0) begin
        mode_d = mode_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    aluCtl_d  = aluCtl_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    capture_d = capture_q;
    opCount_d = opCount_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          aluA_d   = a;
          aluB_d   = b;
          aluCtl_d = mode_q;
          settle_d = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          capture_d = {alu_carry, alu_zero, alu_overflow, alu_result};
          opCount_d = opCount_q + 8'd1;
          state_d   = DONE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      stable_q  <= '0;
      mode_q    <= '0;
      settle_q  <= '0;
      aluCtl_q  <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      capture_q <= '0;
      opCount_q <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      stable_q  <= stable;
      mode_q    <= mode_d;
      settle_q  <= settle_d;
      aluCtl_q  <= aluCtl_d;
      aluA_q    <= aluA_d;
      aluB_q    <= aluB_d;
      capture_q <= capture_d;
      opCount_q <= opCount_d;
    end
  end

  assign alu_control = aluCtl_q;
  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign control_led = mode_q;
  assign carry       = capture_q[6];
  assign zero        = capture_q[5];
  assign overflow    = capture_q[4];
  assign result      = capture_q[3:0];
  assign op_count    = opCount_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU hung off the
// alu_* ports; expected results are queued at start and checked on done.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, start;
  logic [3:0] a, b;
  logic [3:0] alu_result;
  logic       alu_carry, alu_zero, alu_overflow;
  logic [2:0] alu_control;
  logic [3:0] alu_a, alu_b;
  logic [2:0] control_led;
  logic [3:0] result;
  logic       carry, zero, overflow, busy, done;
  logic [7:0] op_count;

  typedef struct {
    logic [6:0]  flagsRes;
    logic [7:0]  cnt;
    logic [10:0] ops;
  } exp_t;

  exp_t       sbQ[$];
  exp_t       monE;
  int         testCount = 0;
  int         failCount = 0;
  logic [2:0] modelMode = 3'd0;
  logic [7:0] modelOpCount = 8'd0;

  alu_op_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .start(start),
    .a(a), .b(b), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .control_led(control_led), .result(result),
    .carry(carry), .zero(zero), .overflow(overflow), .busy(busy), .done(done),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Returns {carry, zero, overflow, result[3:0]}.
  function automatic logic [6:0] aluModel(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] w;
    logic [3:0] r;
    logic       c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin w = {1'b0, x} + {1'b0, y}; r = w[3:0]; c = w[4]; v = (x[3] == y[3]) && (r[3] != x[3]); end
      3'd1: begin w = {1'b0, x} - {1'b0, y}; r = w[3:0]; c = w[4]; v = (x[3] != y[3]) && (r[3] != x[3]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~x;
      3'd6: begin r = {x[2:0], 1'b0}; c = x[3]; end
      default: begin r = {1'b0, x[3:1]}; c = x[0]; end
    endcase
    return {c, (r == 4'd0), v, r};
  endfunction

  assign {alu_carry, alu_zero, alu_overflow, alu_result} = aluModel(alu_control, alu_a, alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("resultFlags", {25'd0, carry, zero, overflow, result}, {25'd0, monE.flagsRes});
        checkOutput("opCount", {24'd0, op_count}, {24'd0, monE.cnt});
        checkOutput("latchedOps", {21'd0, alu_control, alu_a, alu_b}, {21'd0, monE.ops});
      end
    end
  end

  task automatic pushExpected(input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    modelOpCount = modelOpCount + 8'd1;
    e.flagsRes = aluModel(modelMode, x, y);
    e.cnt      = modelOpCount;
    e.ops      = {modelMode, x, y};
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    pushExpected(x, y);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && sbQ.size() != 0; i++) @(negedge clk);
    if (sbQ.size() != 0) begin
      checkOutput("doneTimeout", sbQ.size(), 32'd0);
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic pressButtons(input logic up, input logic dn);
    @(negedge clk);
    btn_up = up; btn_down = dn;
    repeat (20) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (8) @(negedge clk);
    if (up && !dn && modelMode != 3'd7) modelMode = modelMode + 3'd1;
    if (dn && !up && modelMode != 3'd0) modelMode = modelMode - 3'd1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; btn_up = 1'b1; btn_down = 1'b0; a = 4'hF; b = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {1'b0, alu_control, alu_a, alu_b, control_led, result, carry, zero,
                overflow, busy, done, op_count}, 32'd0);
    rst = 1'b1; start = 1'b0; btn_up = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idleAfterReset", {30'd0, busy, done}, 32'd0);

    // Short glitch must not register
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("shortPress", {29'd0, control_led}, 32'd0);

    // Long press: mode changes on the 7th edge after the rise
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("pressNotYet", {29'd0, control_led}, 32'd0);
    @(negedge clk);
    checkOutput("pressOnTime", {29'd0, control_led}, 32'd1);
    repeat (13) @(negedge clk);
    checkOutput("heldOnce", {29'd0, control_led}, 32'd1);
    btn_up = 1'b0;
    repeat (8) @(negedge clk);
    modelMode = 3'd1;
    pressButtons(1'b0, 1'b1);
    checkOutput("downToZero", {29'd0, control_led}, {29'd0, modelMode});

    // Single op with exact done timing
    @(negedge clk);
    a = 4'h3; b = 4'h5; start = 1'b1;
    pushExpected(4'h3, 4'h5);
    @(negedge clk);
    start = 1'b0;
    checkOutput("doneEarly", {31'd0, done}, 32'd0);
    checkOutput("busyExec", {31'd0, busy}, 32'd1);
    checkOutput("latchA", {28'd0, alu_a}, 32'h3);
    checkOutput("latchB", {28'd0, alu_b}, 32'h5);
    @(negedge clk);
    checkOutput("doneOnTime", {31'd0, done}, 32'd1);
    @(negedge clk);
    checkOutput("donePulse", {30'd0, busy, done}, 32'd0);
    checkOutput("opResult", {28'd0, result}, 32'h8);
    checkOutput("opOverflow", {31'd0, overflow}, 32'd1);
    checkOutput("opCountOne", {24'd0, op_count}, 32'd1);
    checkOutput("latchHeld", {24'd0, alu_a, alu_b}, 32'h35);

    // Up press and repeated start landing while busy are both dropped
    @(negedge clk);
    btn_up = 1'b1;
    repeat (5) @(negedge clk);
    a = 4'h6; b = 4'h2; start = 1'b1;
    pushExpected(4'h6, 4'h2);
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    btn_up = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("busyPressDropped", {29'd0, control_led}, 32'd0);
    checkOutput("busySingleOp", {24'd0, op_count}, {24'd0, modelOpCount});
    checkOutput("busyQueueEmpty", sbQ.size(), 32'd0);

    // Saturation at both ends and simultaneous presses
    for (int i = 0; i < 9; i++) pressButtons(1'b1, 1'b0);
    checkOutput("saturateHigh", {29'd0, control_led}, 32'd7);
    for (int i = 0; i < 10; i++) pressButtons(1'b0, 1'b1);
    checkOutput("saturateLow", {29'd0, control_led}, 32'd0);
    for (int i = 0; i < 3; i++) pressButtons(1'b1, 1'b0);
    pressButtons(1'b1, 1'b1);
    checkOutput("simultaneous", {29'd0, control_led}, 32'd3);

    applyStimulus(4'hA, 4'h5);
    applyStimulus(4'h0, 4'h0);
    pressButtons(1'b0, 1'b1);
    applyStimulus(4'h9, 4'hC);

    // Reset while in EXEC discards the operation
    @(negedge clk);
    a = 4'h1; b = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelMode = 3'd0; modelOpCount = 8'd0;
    repeat (5) @(negedge clk);
    checkOutput("midOpReset", {22'd0, busy, done, op_count}, 32'd0);

    for (int i = 0; i < 256; i++) applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    checkOutput("opCountWrap", {24'd0, op_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
